ws2812b_meter_seq: RTL and testbench

//  Parametrised WS2812B bar-graph driver: serialises MAX_LEDS-deep frames of 24-bit

---
 rtl/ws2812b_meter_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ws2812b_meter_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_meter_seq.sv
// Purpose : WS2812B bar-graph driver; streams shadowed MAX_LEDS-deep colour frames onto DOUT.
// Latency : first data edge one cycle after the latch/reset gap; frame_done one cycle after last bit.
// Backpr. : none; frames run free while enable is high, a started frame always completes.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                run frames back-to-back while high (sampled at end of RESET)
//   colors[24*SEG_N]      band s colour at [24*s +: 24], sent MSB first
//   seg_ends[16*SEG_N]    band s covers LED indices below seg_ends[16*s +: 16]
//   on_count, max_count   lit LEDs / driven LEDs for the next frame
//   busy                  high while in RESET or DATA
//   frame_done            one-cycle pulse entering RESET after a frame
//   DOUT                  serial data to the strip
module ws2812b_meter_seq #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int SEG_N         = 4,
    parameter int MAX_LEDS      = 256,
    parameter int T0H_NS        = 400,
    parameter int T0L_NS        = 850,
    parameter int T1H_NS        = 800,
    parameter int T1L_NS        = 450,
    parameter int RESET_NS      = 100000,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [24*SEG_N-1:0]   colors,
    input  logic [16*SEG_N-1:0]   seg_ends,
    input  logic [15:0]           on_count,
    input  logic [15:0]           max_count,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  DOUT
);

    localparam logic [CNT_W-1:0] T0H_CYC  = CNT_W'(T0H_NS / CLK_PERIOD_NS);
    localparam logic [CNT_W-1:0] T1H_CYC  = CNT_W'(T1H_NS / CLK_PERIOD_NS);
    localparam logic [CNT_W-1:0] T0_LAST  = CNT_W'((T0H_NS / CLK_PERIOD_NS) + (T0L_NS / CLK_PERIOD_NS) - 1);
    localparam logic [CNT_W-1:0] T1_LAST  = CNT_W'((T1H_NS / CLK_PERIOD_NS) + (T1L_NS / CLK_PERIOD_NS) - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'((RESET_NS / CLK_PERIOD_NS) - 1);
    localparam logic [15:0]      MAX_LEDS_W = 16'(MAX_LEDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_DATA
    } state_t;

    state_t               state;
    state_t               nextState;

    logic [CNT_W-1:0]     cnt;
    logic [15:0]          ledIdx;
    logic [4:0]           bitIdx;
    logic [23:0]          curColor;

    logic [24*SEG_N-1:0]  shColors;
    logic [16*SEG_N-1:0]  shSegEnds;
    logic [15:0]          shEffOn;
    logic [15:0]          shEffMax;

    logic [15:0]          liveEffMax;
    logic [15:0]          liveEffOn;
    logic                 curBit;
    logic [CNT_W-1:0]     hiCyc;
    logic [CNT_W-1:0]     bitLastCnt;
    logic                 rstLast;
    logic                 bitLast;
    logic                 lastLed;
    logic                 frameEmpty;
    logic                 dataEnd;
    logic [23:0]          nextColor;
    logic [23:0]          firstColor;

    // Lowest-numbered band whose end lies above idx wins; if none does the
    // top band is used. Anything at or past the lit count is black.
    function automatic logic [23:0] ledColor(
        input logic [15:0]          idx,
        input logic [24*SEG_N-1:0]  cols,
        input logic [16*SEG_N-1:0]  ends,
        input logic [15:0]          onLimit
    );
        logic [23:0] c;
        c = cols[24*(SEG_N-1) +: 24];
        for (int s = SEG_N - 1; s >= 0; s--) begin
            if (idx < ends[16*s +: 16]) begin
                c = cols[24*s +: 24];
            end
        end
        if (idx >= onLimit) begin
            c = 24'h000000;
        end
        return c;
    endfunction

    always_comb begin
        liveEffMax = (max_count > MAX_LEDS_W) ? MAX_LEDS_W : max_count;
        liveEffOn  = (on_count > liveEffMax) ? liveEffMax : on_count;
        curBit     = curColor[5'd23 - bitIdx];
        hiCyc      = curBit ? T1H_CYC : T0H_CYC;
        bitLastCnt = curBit ? T1_LAST : T0_LAST;
        rstLast    = (cnt == RST_LAST);
        bitLast    = (cnt == bitLastCnt);
        lastLed    = (ledIdx == shEffMax - 16'd1);
        frameEmpty = (shEffMax == 16'd0);
        // An empty frame spends a single DATA cycle with DOUT low, then reports done.
        dataEnd    = frameEmpty || (bitLast && (bitIdx == 5'd23) && lastLed);
        // The following LED's colour is resolved while the current one shifts
        // out, so LED boundaries carry no idle cycle.
        nextColor  = ledColor(ledIdx + 16'd1, shColors, shSegEnds, shEffOn);
        // LED 0 is resolved from the live inputs in the same cycle they are shadowed.
        firstColor = ledColor(16'd0, colors, seg_ends, liveEffOn);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        DOUT      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    nextState = S_RESET;
                end
            end
            S_RESET: begin
                busy = 1'b1;
                if (rstLast) begin
                    nextState = enable ? S_DATA : S_IDLE;
                end
            end
            S_DATA: begin
                busy = 1'b1;
                DOUT = !frameEmpty && (cnt < hiCyc);
                if (dataEnd) begin
                    nextState = S_RESET;
                end
            end
            default: begin
                nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            ledIdx     <= '0;
            bitIdx     <= '0;
            curColor   <= '0;
            shColors   <= '0;
            shSegEnds  <= '0;
            shEffOn    <= '0;
            shEffMax   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                end
                S_RESET: begin
                    if (rstLast) begin
                        cnt <= '0;
                        if (enable) begin
                            shColors  <= colors;
                            shSegEnds <= seg_ends;
                            shEffOn   <= liveEffOn;
                            shEffMax  <= liveEffMax;
                            ledIdx    <= '0;
                            bitIdx    <= '0;
                            curColor  <= firstColor;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (dataEnd) begin
                        frame_done <= 1'b1;
                        cnt        <= '0;
                    end else if (bitLast) begin
                        cnt <= '0;
                        if (bitIdx == 5'd23) begin
                            bitIdx   <= '0;
                            ledIdx   <= ledIdx + 16'd1;
                            curColor <= nextColor;
                        end else begin
                            bitIdx <= bitIdx + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_meter_seq.sv
module tb_ws2812b_meter_seq;

    localparam int MAXL = 8;
    localparam int RSTC = 100;
    localparam int T1H  = 80;
    localparam int T1L  = 45;
    localparam int T0H  = 40;
    localparam int T0L  = 85;
    localparam int BITC = 125;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [95:0] colors;
    logic [63:0] seg_ends;
    logic [15:0] on_count;
    logic [15:0] max_count;
    logic        busy;
    logic        frame_done;
    logic        DOUT;

    always #5 clk = ~clk;

    ws2812b_meter_seq #(
        .MAX_LEDS (MAXL),
        .RESET_NS (1000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .colors     (colors),
        .seg_ends   (seg_ends),
        .on_count   (on_count),
        .max_count  (max_count),
        .busy       (busy),
        .frame_done (frame_done),
        .DOUT       (DOUT)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Reference model: colour of LED i straight from the band rules.
    function automatic logic [23:0] expColor(int i, logic [95:0] c, logic [63:0] e, int on, int mx);
        int effMax;
        int effOn;
        effMax = (mx < MAXL) ? mx : MAXL;
        effOn  = (on < effMax) ? on : effMax;
        if (i >= effOn) return 24'h0;
        for (int s = 0; s < 4; s++) begin
            if (i < int'(e[16*s +: 16])) return c[24*s +: 24];
        end
        return c[72 +: 24];
    endfunction

    logic [23:0] expQ[$];
    int          lenQ[$];
    int          doneAt[$];

    task automatic pushFrame(input logic [95:0] c, input logic [63:0] e, input int on, input int mx);
        int n;
        colors    = c;
        seg_ends  = e;
        on_count  = 16'(on);
        max_count = 16'(mx);
        n = (mx < MAXL) ? mx : MAXL;
        for (int i = 0; i < n; i++) expQ.push_back(expColor(i, c, e, on, mx));
        lenQ.push_back(n);
    endtask

    function automatic logic [95:0] randCols();
        logic [95:0] v;
        v = {$urandom(), $urandom(), $urandom()};
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit          monEn = 1'b0;
    bit          finalPhase = 1'b0;
    int          finalDone = -1;
    int          ncyc = 0;
    int          riseCnt = 0;
    int          doneCnt = 0;
    bit          prevDout = 1'b0;
    bit          inBit = 1'b0;
    int          hiCnt = 0;
    int          loCnt = 0;
    int          bitsInFrame = 0;
    bit          havePrev = 1'b0;
    int          prevDone = 0;
    logic [23:0] word = '0;

    task automatic finishBit();
        bit b;
        bit ok;
        ok = 1'b1;
        b  = 1'b0;
        if (hiCnt == T1H && loCnt == T1L) b = 1'b1;
        else if (!(hiCnt == T0H && loCnt == T0L)) ok = 1'b0;
        checks++;
        if (ok) passes++;
        else $display("FAIL bit_width: high %0d low %0d cycles, required 80/45 or 40/85", hiCnt, loCnt);
        word = {word[22:0], b};
        bitsInFrame++;
        if (bitsInFrame % 24 == 0) begin
            if (expQ.size() == 0) check("led_unexpected", 64'(word), 64'hffffffffffffffff);
            else check("led_color", 64'(word), 64'(expQ.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        int n;
        ncyc++;
        if (DOUT && !prevDout) riseCnt++;
        if (frame_done) begin
            doneCnt++;
            doneAt.push_back(ncyc);
        end
        if (!monEn) begin
            inBit = 1'b0; hiCnt = 0; loCnt = 0; bitsInFrame = 0; havePrev = 1'b0;
        end else begin
            if (frame_done) begin
                if (inBit) finishBit();
                inBit = 1'b0;
                if (lenQ.size() == 0) begin
                    check("frame_unexpected", 64'(bitsInFrame), 64'hffffffffffffffff);
                end else begin
                    n = lenQ.pop_front();
                    check("frame_bits", 64'(bitsInFrame), 64'(n * 24));
                    if (havePrev)
                        check("frame_period", 64'(ncyc - prevDone), 64'(RSTC + ((n == 0) ? 1 : n * 24 * BITC)));
                end
                havePrev = 1'b1;
                prevDone = ncyc;
                bitsInFrame = 0;
                if (finalPhase && finalDone < 0) finalDone = ncyc;
            end else if (DOUT) begin
                if (!prevDout) begin
                    if (inBit) finishBit();
                    inBit = 1'b1; hiCnt = 1; loCnt = 0;
                end else begin
                    hiCnt++;
                end
            end else if (inBit) begin
                loCnt++;
            end
            if (finalDone >= 0 && ncyc == finalDone + RSTC - 1) check("busy_last_reset", 64'(busy), 64'd1);
            if (finalDone >= 0 && ncyc == finalDone + RSTC)     check("busy_idle", 64'(busy), 64'd0);
        end
        prevDout = DOUT;
    end

    // ---------------- stimulus ----------------
    task automatic waitDone(input int k);
        int t;
        t = 0;
        while (doneCnt < k && t < 30000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("wait_frame_done", 64'(doneCnt >= k), 64'd1);
    endtask

    task automatic waitAfterDone(input int k, input int dly);
        int target;
        int t;
        target = (doneAt.size() >= k) ? doneAt[k-1] + dly : ncyc + dly;
        t = 0;
        while (ncyc < target && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    initial begin
        int r0;
        int d0;
        int t;
        logic [63:0] e;
        reset_n   = 1'b0;
        enable    = 1'b0;
        colors    = '0;
        seg_ends  = '0;
        on_count  = '0;
        max_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 64'(DOUT), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of LED 3.
        colors    = randCols() | 96'hffffff_ffffff_ffffff_ffffff;
        seg_ends  = {16'd4, 16'd3, 16'd2, 16'd1};
        on_count  = 16'd4;
        max_count = 16'd4;
        @(posedge clk); #1;
        enable = 1'b1;
        t = 0;
        while (riseCnt < 75 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("wait_led3", 64'(riseCnt >= 75), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_dout", 64'(DOUT), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_dout", 64'(DOUT), 64'd0);
        check("async_reset_busy", 64'(busy), 64'd0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        r0 = riseCnt;
        d0 = doneCnt;
        repeat (150) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_no_edges", 64'(riseCnt), 64'(r0));
        check("idle_no_done", 64'(doneCnt), 64'(d0));

        // Continuous frames; each new config is applied while the previous frame runs.
        monEn = 1'b1;
        d0 = doneCnt;
        pushFrame(randCols(), {16'd8, 16'd6, 16'd4, 16'd2}, 5, 8);
        enable = 1'b1;
        repeat (110) @(posedge clk);
        #1;
        check("busy_in_data", 64'(busy), 64'd1);
        pushFrame(randCols(), {16'd1, 16'd2, 16'd3, 16'd4}, 3, 0);
        waitDone(d0 + 1);
        waitAfterDone(d0 + 1, 105);
        pushFrame(randCols(), 64'($urandom()), 7, 0);
        waitDone(d0 + 2);
        waitAfterDone(d0 + 2, 105);
        for (int s = 0; s < 4; s++) e[16*s +: 16] = 16'($urandom_range(0, 10));
        pushFrame(randCols(), e, $urandom_range(0, 12), 300);
        waitDone(d0 + 3);
        waitAfterDone(d0 + 3, 105);
        pushFrame(randCols(), 64'd0, 10, 4);
        waitDone(d0 + 4);
        waitAfterDone(d0 + 4, 105);
        check("busy_mid_frame", 64'(busy), 64'd1);
        finalPhase = 1'b1;
        enable = 1'b0;
        waitDone(d0 + 5);
        repeat (RSTC + 20) @(posedge clk);
        #1;
        check("final_busy", 64'(busy), 64'd0);
        check("final_dout", 64'(DOUT), 64'd0);
        check("final_idle_seen", 64'(finalDone >= 0), 64'd1);
        r0 = riseCnt;
        d0 = doneCnt;
        repeat (100) @(posedge clk);
        #1;
        check("final_no_edges", 64'(riseCnt), 64'(r0));
        check("final_no_done", 64'(doneCnt), 64'(d0));
        check("led_queue_empty", 64'(expQ.size()), 64'd0);
        check("frame_queue_empty", 64'(lenQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
